// File: rtl/ifetch_buffer_pkg.sv
// Purpose: shared types for the instruction prefetch slice (addresses, words, FIFO entries).
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package ifetch_buffer_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic        enable_t;

  localparam int unsigned INST_BYTES = 4;

  // One queued fetch result: the PC it was fetched from and the returned word.
  typedef struct packed {
    addr_t pc;
    data_t inst;
  } fetch_entry_t;

  // Clear the byte-offset bits so every fetch address is word aligned.
  function automatic addr_t word_align(input addr_t a);
    return a & ~addr_t'(INST_BYTES - 1);
  endfunction

endpackage

// File: rtl/ifetch_buffer_if.sv
// Purpose: bundles the memory fetch port, the redirect input and the decode handshake.
// Latency: n/a (wires only).
// Backpressure: inst_ready_i from the consumer; imem side has none (fixed 1-cycle return).
// Ports: master = prefetch stage (drives imem_addr_o/imem_ren_o and the inst_* outputs),
//        slave  = surrounding system (memory, execute redirect, decode).
interface ifetch_buffer_if;
  import ifetch_buffer_pkg::*;

  addr_t   imem_addr_o;
  enable_t imem_ren_o;
  data_t   imem_data_i;
  enable_t redirect_i;
  addr_t   redirect_pc_i;
  enable_t inst_valid_o;
  data_t   inst_o;
  addr_t   inst_pc_o;
  enable_t inst_ready_i;

  modport master (
    output imem_addr_o, imem_ren_o,
    input  imem_data_i,
    input  redirect_i, redirect_pc_i,
    output inst_valid_o, inst_o, inst_pc_o,
    input  inst_ready_i
  );

  modport slave (
    input  imem_addr_o, imem_ren_o,
    output imem_data_i,
    output redirect_i, redirect_pc_i,
    input  inst_valid_o, inst_o, inst_pc_o,
    output inst_ready_i
  );

endinterface

// File: rtl/ifetch_buffer_fetch_fifo.sv
// Purpose: DEPTH-entry queue of fetch_entry_t with push/pop/flush and an occupancy count.
// Latency: a push is visible at the head on the following cycle (registered storage, no bypass).
// Backpressure: none internally; the caller must never push into a full queue.
// Ports: flush/push/pop controls, push_entry in, head out (entry at rd_ptr), count out.
module fetch_fifo
  import ifetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4  // power of two, >= 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  fetch_entry_t           push_entry,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Flush wins over both push and pop; a pop on an empty queue is ignored.
  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  assign head = mem[rd_ptr];

  // The issue side reserves a slot before fetching, so a push into a full
  // queue means the credit accounting is broken.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(do_push && !do_pop && (count == FULL)));

endmodule

// File: rtl/ifetch_buffer.sv
// Purpose: instruction prefetch stage; issues sequential fetches, queues {pc, inst}, hands them to decode.
// Latency: issue at cycle t -> instruction visible at t+2 when the queue was empty; 1 inst/cycle steady state.
// Backpressure: inst_ready_i low fills the queue; fetch stops when queued + in-flight reaches DEPTH.
// Ports: clk, rst_n (async active-low), bus (ifetch_buffer_if.master: imem port, redirect, decode handshake).
module ifetch_buffer
  import ifetch_buffer_pkg::*;
#(
  parameter int    DEPTH    = 4,             // power of two, >= 2
  parameter addr_t RESET_PC = 32'h0000_0000
) (
  input logic             clk,
  input logic             rst_n,
  ifetch_buffer_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  addr_t          fetch_pc_q;
  addr_t          issued_pc_q;
  logic           inflight_q;
  logic           run_q;

  logic [CW-1:0]  count;
  logic [CW:0]    occupancy;
  logic           credit;
  logic           push;
  logic           pop;
  fetch_entry_t   push_entry;
  fetch_entry_t   head;

  // Slots already committed: entries queued plus the word still returning.
  // A pop in the same cycle is deliberately not credited, which keeps the
  // issue decision off the consumer's ready path.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q};
  assign credit    = run_q && (occupancy < (CW + 1)'(DEPTH));

  // A redirect always issues: it flushes the queue and kills the in-flight
  // word, so a slot is guaranteed and the new path starts without a bubble.
  assign bus.imem_ren_o  = run_q && (bus.redirect_i || credit);
  assign bus.imem_addr_o = bus.redirect_i ? word_align(bus.redirect_pc_i) : fetch_pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      fetch_pc_q  <= RESET_PC;
      issued_pc_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      inflight_q <= bus.imem_ren_o;
      if (bus.imem_ren_o) begin
        fetch_pc_q  <= bus.imem_addr_o + addr_t'(INST_BYTES);
        issued_pc_q <= bus.imem_addr_o;
      end
    end
  end

  // A word returning in a redirect cycle belongs to the old path and is dropped.
  assign push       = inflight_q && !bus.redirect_i;
  assign push_entry = '{pc: issued_pc_q, inst: bus.imem_data_i};

  assign bus.inst_valid_o = (count != '0) && !bus.redirect_i;
  assign pop              = bus.inst_valid_o && bus.inst_ready_i;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fetch_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.redirect_i),
    .push      (push),
    .pop       (pop),
    .push_entry(push_entry),
    .head      (head),
    .count     (count)
  );

  assign bus.inst_o    = head.inst;
  assign bus.inst_pc_o = head.pc;

endmodule

// File: tb/tb_ifetch_buffer.sv
// Purpose: directed self-checking bench for ifetch_buffer (plus a second instance with a wrapping RESET_PC).
// Latency: memory models return addr/4 one cycle after each fetch request.
// Backpressure: inst_ready_i driven per test; the wrapping instance always accepts.
module tb_ifetch_buffer;
  import ifetch_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  ifetch_buffer_if ifc ();
  ifetch_buffer_if ifw ();

  ifetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  ifetch_buffer #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifw)
  );

  // Instruction memories: word at address A holds A/4, returned next cycle.
  always @(posedge clk) if (ifc.imem_ren_o) ifc.imem_data_i <= {2'b00, ifc.imem_addr_o[31:2]};
  always @(posedge clk) if (ifw.imem_ren_o) ifw.imem_data_i <= {2'b00, ifw.imem_addr_o[31:2]};

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  addr_t iss[$];
  addr_t wrap_pc   [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
  data_t wrap_inst [4] = '{32'h3FFF_FFFE, 32'h3FFF_FFFF, 32'h0000_0000, 32'h0000_0001};

  initial begin
    ifc.redirect_i    = 1'b0;
    ifc.redirect_pc_i = '0;
    ifc.inst_ready_i  = 1'b1;
    ifw.redirect_i    = 1'b0;
    ifw.redirect_pc_i = '0;
    ifw.inst_ready_i  = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst_valid", 32'(ifc.inst_valid_o), 0);
    check_eq("rst_ren",   32'(ifc.imem_ren_o),   0);
    check_eq("rst_inst",  ifc.inst_o,            0);
    check_eq("rst_pc",    ifc.inst_pc_o,         0);

    // Test 1 + 6: release, sequential fetch, first valid two cycles after issue
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("t1_no_ren_before_run", 32'(ifc.imem_ren_o), 0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check_eq($sformatf("t1_ren_%0d", k),   32'(ifc.imem_ren_o), 1);
      check_eq($sformatf("t1_addr_%0d", k),  ifc.imem_addr_o, 32'(4 * k));
      check_eq($sformatf("t1_valid_%0d", k), 32'(ifc.inst_valid_o), (k >= 2) ? 1 : 0);
      check_eq($sformatf("t6_valid_%0d", k), 32'(ifw.inst_valid_o), (k >= 2) ? 1 : 0);
      if (k >= 2) begin
        check_eq($sformatf("t1_pc_%0d", k),   ifc.inst_pc_o, 32'(4 * (k - 2)));
        check_eq($sformatf("t1_inst_%0d", k), ifc.inst_o,    32'(k - 2));
        check_eq($sformatf("t6_pc_%0d", k),   ifw.inst_pc_o, wrap_pc[k - 2]);
        check_eq($sformatf("t6_inst_%0d", k), ifw.inst_o,    wrap_inst[k - 2]);
      end
    end

    // Test 2: consumer stalled, queue fills to DEPTH, head stays stable
    ifc.inst_ready_i = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ifc.imem_ren_o) iss.push_back(ifc.imem_addr_o);
      if (k >= 3) begin
        check_eq($sformatf("t2_hold_valid_%0d", k), 32'(ifc.inst_valid_o), 1);
        check_eq($sformatf("t2_hold_pc_%0d", k),    ifc.inst_pc_o, 32'h0);
      end
      @(posedge clk); #1;
    end
    check_eq("t2_issue_count", 32'(iss.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < iss.size()) check_eq($sformatf("t2_issue_addr_%0d", i), iss[i], 32'(4 * i));
    end
    ifc.inst_ready_i = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check_eq($sformatf("t2_drain_valid_%0d", j), 32'(ifc.inst_valid_o), 1);
      check_eq($sformatf("t2_drain_pc_%0d", j),    ifc.inst_pc_o, 32'(4 * j));
      check_eq($sformatf("t2_drain_inst_%0d", j),  ifc.inst_o,    32'(j));
      @(posedge clk); #1;
    end

    // Test 3: redirect with two queued and one in flight
    ifc.redirect_i    = 1'b1;
    ifc.redirect_pc_i = 32'h0000_0100;
    @(negedge clk);
    check_eq("t3_valid_in_redirect", 32'(ifc.inst_valid_o), 0);
    check_eq("t3_ren_in_redirect",   32'(ifc.imem_ren_o),   1);
    check_eq("t3_addr_in_redirect",  ifc.imem_addr_o,       32'h0000_0100);
    @(posedge clk); #1;
    ifc.redirect_i = 1'b0;
    for (int m = 1; m < 5; m++) begin
      @(negedge clk);
      if (m == 1) begin
        check_eq("t3_gap_valid", 32'(ifc.inst_valid_o), 0);
      end else begin
        check_eq($sformatf("t3_valid_%0d", m), 32'(ifc.inst_valid_o), 1);
        check_eq($sformatf("t3_pc_%0d", m),    ifc.inst_pc_o, 32'h100 + 32'(4 * (m - 2)));
        check_eq($sformatf("t3_inst_%0d", m),  ifc.inst_o,    32'h40 + 32'(m - 2));
      end
      @(posedge clk); #1;
    end

    // Test 4: back-to-back redirects, only the second path survives
    ifc.redirect_i    = 1'b1;
    ifc.redirect_pc_i = 32'h0000_0200;
    @(negedge clk);
    check_eq("t4_addr_first", ifc.imem_addr_o, 32'h0000_0200);
    @(posedge clk); #1;
    ifc.redirect_pc_i = 32'h0000_0300;
    @(negedge clk);
    check_eq("t4_valid_second", 32'(ifc.inst_valid_o), 0);
    check_eq("t4_addr_second",  ifc.imem_addr_o, 32'h0000_0300);
    @(posedge clk); #1;
    ifc.redirect_i = 1'b0;
    for (int m = 0; m < 4; m++) begin
      @(negedge clk);
      if (m == 0) begin
        check_eq("t4_gap_valid", 32'(ifc.inst_valid_o), 0);
      end else begin
        check_eq($sformatf("t4_valid_%0d", m), 32'(ifc.inst_valid_o), 1);
        check_eq($sformatf("t4_pc_%0d", m),    ifc.inst_pc_o, 32'h300 + 32'(4 * (m - 1)));
      end
      @(posedge clk); #1;
    end

    // Test 5: unaligned redirect target is word aligned
    ifc.redirect_i    = 1'b1;
    ifc.redirect_pc_i = 32'h0000_0203;
    @(negedge clk);
    check_eq("t5_ren",  32'(ifc.imem_ren_o), 1);
    check_eq("t5_addr", ifc.imem_addr_o, 32'h0000_0200);
    @(posedge clk); #1;
    ifc.redirect_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("t5_pc",   ifc.inst_pc_o, 32'h0000_0200);
    check_eq("t5_inst", ifc.inst_o,    32'h0000_0080);

    // Test 7: asynchronous reset mid-burst
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_eq("t7_valid_async", 32'(ifc.inst_valid_o), 0);
    check_eq("t7_ren_async",   32'(ifc.imem_ren_o),   0);
    check_eq("t7_pc_async",    ifc.inst_pc_o,         0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("t7_no_ren_before_run", 32'(ifc.imem_ren_o), 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check_eq($sformatf("t7_addr_%0d", k), ifc.imem_addr_o, 32'(4 * k));
      check_eq($sformatf("t7_valid_%0d", k), 32'(ifc.inst_valid_o), (k >= 2) ? 1 : 0);
    end
    check_eq("t7_first_pc", ifc.inst_pc_o, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
